// File: rtl/fir_tcdm_arbiter.sv
// Round-robin arbiter sharing one TCDM port among the FIR x/h/y streams, with in-order response routing.
// Optional macro FIR_TCDM_ARB_BURST_LOCK_EN: hold a requesting port for up to 4 consecutive grants.
module fir_tcdm_arbiter #(
   parameter int MP              = 3,
   parameter int DW              = 32,
   parameter int AW              = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 enable_i,
   input  logic                 clear_i,
   input  logic [MP-1:0]        in_req_i,
   output logic [MP-1:0]        in_gnt_o,
   input  logic [MP*AW-1:0]     in_add_i,
   input  logic [MP-1:0]        in_wen_i,
   input  logic [MP*DW/8-1:0]   in_be_i,
   input  logic [MP*DW-1:0]     in_data_i,
   output logic [DW-1:0]        in_r_data_o,
   output logic [MP-1:0]        in_r_valid_o,
   output logic                 out_req_o,
   input  logic                 out_gnt_i,
   output logic [AW-1:0]        out_add_o,
   output logic                 out_wen_o,
   output logic [DW/8-1:0]      out_be_o,
   output logic [DW-1:0]        out_data_o,
   input  logic [DW-1:0]        out_r_data_i,
   input  logic                 out_r_valid_i,
   output logic                 err_o
);

   localparam int PW = (MP > 1) ? $clog2(MP) : 1;
   localparam int FW = $clog2(MAX_OUTSTANDING);
   localparam int BW = DW / 8;
   localparam logic [FW:0] FULL = (FW+1)'(MAX_OUTSTANDING);

   logic [PW-1:0] ptr;
   logic [PW-1:0] sel;
   logic [PW-1:0] head;
   logic [PW:0]   cand;
   logic          found;
   logic          push;
   logic          pop;
   logic          err;
   logic [FW:0]   cnt;
   logic [FW-1:0] wr_ptr;
   logic [FW-1:0] rd_ptr;
   logic [PW-1:0] id_fifo [MAX_OUTSTANDING];

   function automatic logic [PW-1:0] next_port(input logic [PW-1:0] p);
      return (p == PW'(MP-1)) ? '0 : p + PW'(1);
   endfunction

   // cyclic priority scan starting at ptr
   always_comb begin
      sel   = ptr;
      found = 1'b0;
      cand  = '0;
      for (int k = 0; k < MP; k++) begin
         cand = {1'b0, ptr} + (PW+1)'(k);
         if (cand >= (PW+1)'(MP)) cand = cand - (PW+1)'(MP);
         if (!found && in_req_i[cand[PW-1:0]]) begin
            sel   = cand[PW-1:0];
            found = 1'b1;
         end
      end
   end

   assign head      = id_fifo[rd_ptr];
   assign out_req_o = rst_ni & enable_i & (|in_req_i) & (cnt < FULL);
   assign push      = out_req_o & out_gnt_i;
   assign pop       = rst_ni & out_r_valid_i & (cnt != '0);

   assign out_add_o  = in_add_i[int'(sel)*AW +: AW];
   assign out_wen_o  = in_wen_i[sel];
   assign out_be_o   = in_be_i[int'(sel)*BW +: BW];
   assign out_data_o = in_data_i[int'(sel)*DW +: DW];

   assign in_r_data_o = out_r_data_i;
   assign err_o       = err;

   always_comb begin
      in_gnt_o     = '0;
      in_r_valid_o = '0;
      if (push) in_gnt_o[sel]      = 1'b1;
      if (pop)  in_r_valid_o[head] = 1'b1;
   end

   // in-order ID FIFO bookkeeping and sticky error
   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
         cnt    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         err    <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + FW'(1);
         if (pop)  rd_ptr <= rd_ptr + FW'(1);
         if (push && !pop)      cnt <= cnt + (FW+1)'(1);
         else if (pop && !push) cnt <= cnt - (FW+1)'(1);
         if (out_r_valid_i && cnt == '0) err <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) id_fifo[wr_ptr] <= sel;
   end

`ifdef FIR_TCDM_ARB_BURST_LOCK_EN
   logic [1:0] burst;
   logic [1:0] run;
   logic       locked;

   // a grant to a port other than the locked one starts a fresh run
   assign run = (locked && sel == ptr) ? burst : 2'd0;

   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
         ptr    <= '0;
         burst  <= '0;
         locked <= 1'b0;
      end else if (push) begin
         if (run == 2'd3) begin
            ptr    <= next_port(sel);
            burst  <= '0;
            locked <= 1'b0;
         end else begin
            ptr    <= sel;
            burst  <= run + 2'd1;
            locked <= 1'b1;
         end
      end else if (locked && enable_i && !in_req_i[ptr]) begin
         ptr    <= next_port(ptr);
         burst  <= '0;
         locked <= 1'b0;
      end
   end
`else
   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) ptr <= '0;
      else if (push)          ptr <= next_port(sel);
   end
`endif

endmodule

// File: tb/tb_fir_tcdm_arbiter.sv
// Self-checking bench for fir_tcdm_arbiter: vector table, directed corner sequences, and
// randomized traffic compared against a queue-based reference model.
module tb_fir_tcdm_arbiter;

   localparam int MP = 3;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int MO = 4;
   localparam int BW = DW / 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              enable = 1'b0;
   logic              clear = 1'b0;
   logic [MP-1:0]     in_req = '0;
   logic [MP-1:0]     in_gnt;
   logic [MP*AW-1:0]  in_add = '0;
   logic [MP-1:0]     in_wen = '0;
   logic [MP*BW-1:0]  in_be = '0;
   logic [MP*DW-1:0]  in_data = '0;
   logic [DW-1:0]     in_r_data;
   logic [MP-1:0]     in_r_valid;
   logic              out_req;
   logic              out_gnt = 1'b0;
   logic [AW-1:0]     out_add;
   logic              out_wen;
   logic [BW-1:0]     out_be;
   logic [DW-1:0]     out_data;
   logic [DW-1:0]     out_r_data = '0;
   logic              out_r_valid = 1'b0;
   logic              err;

   fir_tcdm_arbiter #(.MP(MP), .DW(DW), .AW(AW), .MAX_OUTSTANDING(MO)) dut (
      .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .clear_i(clear),
      .in_req_i(in_req), .in_gnt_o(in_gnt), .in_add_i(in_add), .in_wen_i(in_wen),
      .in_be_i(in_be), .in_data_i(in_data), .in_r_data_o(in_r_data), .in_r_valid_o(in_r_valid),
      .out_req_o(out_req), .out_gnt_i(out_gnt), .out_add_o(out_add), .out_wen_o(out_wen),
      .out_be_o(out_be), .out_data_o(out_data), .out_r_data_i(out_r_data),
      .out_r_valid_i(out_r_valid), .err_o(err)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // reference model state: round-robin pointer, queue of granted port IDs, sticky error
   int m_ptr = 0;
   int m_q[$];
   bit m_err = 1'b0;
`ifdef FIR_TCDM_ARB_BURST_LOCK_EN
   int m_burst = 0;
   bit m_locked = 1'b0;
`endif

   typedef struct {
      logic          en;
      logic          clr;
      logic [MP-1:0] req;
      logic          gnt;
      logic          rv;
      logic          e_req;
      logic [MP-1:0] e_gnt;
      logic [MP-1:0] e_rv;
      logic          e_err;
   } vec_t;

   vec_t tbl [15];

   function automatic vec_t mk(logic en, logic clr, logic [MP-1:0] req, logic gnt, logic rv,
                               logic e_req, logic [MP-1:0] e_gnt, logic [MP-1:0] e_rv, logic e_err);
      vec_t v;
      v.en = en; v.clr = clr; v.req = req; v.gnt = gnt; v.rv = rv;
      v.e_req = e_req; v.e_gnt = e_gnt; v.e_rv = e_rv; v.e_err = e_err;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int m_sel();
      for (int k = 0; k < MP; k++)
         if (in_req[(m_ptr + k) % MP]) return (m_ptr + k) % MP;
      return m_ptr;
   endfunction

   // Called shortly after a rising edge with inputs already applied: checks the
   // combinational outputs against the model, then clocks both DUT and model.
   task automatic step();
      int sel;
      bit req, acc;
      logic [MP-1:0] eg, ev;
      #2;
      sel = m_sel();
      req = rst_n && enable && (|in_req) && (m_q.size() < MO);
      acc = req && out_gnt;
      eg  = acc ? (MP'(1) << sel) : '0;
      ev  = '0;
      if (rst_n && out_r_valid && m_q.size() > 0) ev = MP'(1) << m_q[0];
      chk("out_req", 64'(out_req), 64'(req));
      chk("in_gnt", 64'(in_gnt), 64'(eg));
      chk("in_r_valid", 64'(in_r_valid), 64'(ev));
      chk("err", 64'(err), 64'(m_err));
      if (ev != '0) chk("in_r_data", 64'(in_r_data), 64'(out_r_data));
      if (req) begin
         chk("out_add", 64'(out_add), 64'(in_add[sel*AW +: AW]));
         chk("out_data", 64'(out_data), 64'(in_data[sel*DW +: DW]));
         chk("out_be", 64'(out_be), 64'(in_be[sel*BW +: BW]));
         chk("out_wen", 64'(out_wen), 64'(in_wen[sel]));
      end
      @(posedge clk);
      if (!rst_n || clear) begin
         m_ptr = 0;
         m_q.delete();
         m_err = 1'b0;
`ifdef FIR_TCDM_ARB_BURST_LOCK_EN
         m_burst = 0;
         m_locked = 1'b0;
`endif
      end else begin
         if (out_r_valid) begin
            if (m_q.size() > 0) void'(m_q.pop_front());
            else m_err = 1'b1;
         end
`ifdef FIR_TCDM_ARB_BURST_LOCK_EN
         if (acc) begin
            int run;
            m_q.push_back(sel);
            run = (m_locked && sel == m_ptr) ? m_burst : 0;
            if (run == 3) begin
               m_ptr = (sel + 1) % MP; m_burst = 0; m_locked = 1'b0;
            end else begin
               m_ptr = sel; m_burst = run + 1; m_locked = 1'b1;
            end
         end else if (m_locked && enable && !in_req[m_ptr]) begin
            m_ptr = (m_ptr + 1) % MP; m_burst = 0; m_locked = 1'b0;
         end
`else
         if (acc) begin
            m_q.push_back(sel);
            m_ptr = (sel + 1) % MP;
         end
`endif
      end
      #1;
   endtask

   int pc [MP];
   int exp_p;
   logic [MP-1:0] rsp_v [3];
   logic [DW-1:0] rsp_d [3];

   initial begin
      tbl[0]  = mk(1, 0, 3'b000, 1, 0, 0, 3'b000, 3'b000, 0);
      tbl[1]  = mk(1, 0, 3'b000, 1, 1, 0, 3'b000, 3'b000, 0);
      tbl[2]  = mk(1, 0, 3'b000, 1, 0, 0, 3'b000, 3'b000, 1);
      tbl[3]  = mk(1, 1, 3'b000, 1, 0, 0, 3'b000, 3'b000, 1);
      tbl[4]  = mk(1, 0, 3'b000, 1, 0, 0, 3'b000, 3'b000, 0);
      tbl[5]  = mk(1, 0, 3'b010, 1, 0, 1, 3'b010, 3'b000, 0);
      tbl[6]  = mk(1, 0, 3'b010, 1, 0, 1, 3'b010, 3'b000, 0);
      tbl[7]  = mk(1, 0, 3'b010, 1, 0, 1, 3'b010, 3'b000, 0);
      tbl[8]  = mk(1, 0, 3'b010, 1, 0, 1, 3'b010, 3'b000, 0);
      tbl[9]  = mk(1, 0, 3'b010, 1, 0, 0, 3'b000, 3'b000, 0);
      tbl[10] = mk(1, 0, 3'b010, 1, 1, 0, 3'b000, 3'b010, 0);
      tbl[11] = mk(1, 0, 3'b010, 1, 0, 1, 3'b010, 3'b000, 0);
      tbl[12] = mk(0, 0, 3'b010, 1, 1, 0, 3'b000, 3'b010, 0);
      tbl[13] = mk(0, 0, 3'b000, 1, 1, 0, 3'b000, 3'b010, 0);
      tbl[14] = mk(1, 1, 3'b000, 0, 0, 0, 3'b000, 3'b000, 0);

      in_add  = {32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0};
      in_data = {32'hDA7A_0002, 32'hDA7A_0001, 32'hDA7A_0000};
      in_be   = 12'hF3C;
      in_wen  = 3'b101;
      out_r_data = 32'hD00D_0000;

      // reset: outputs forced low even with every input active
      @(posedge clk); #1;
      enable = 1'b1; in_req = '1; out_gnt = 1'b1; out_r_valid = 1'b1;
      step();
      step();
      rst_n = 1'b1; in_req = '0; out_r_valid = 1'b0;

      for (int i = 0; i < 15; i++) begin
         enable = tbl[i].en; clear = tbl[i].clr; in_req = tbl[i].req;
         out_gnt = tbl[i].gnt; out_r_valid = tbl[i].rv;
         #1;
         chk("vec_out_req", 64'(out_req), 64'(tbl[i].e_req));
         chk("vec_in_gnt", 64'(in_gnt), 64'(tbl[i].e_gnt));
         chk("vec_in_r_valid", 64'(in_r_valid), 64'(tbl[i].e_rv));
         chk("vec_err", 64'(err), 64'(tbl[i].e_err));
         step();
      end
      clear = 1'b0; enable = 1'b1; out_gnt = 1'b1; out_r_valid = 1'b0;

      // all ports requesting, immediate responses
      for (int p = 0; p < MP; p++) pc[p] = 0;
      for (int k = 0; k < 12; k++) begin
         in_req = '1;
         out_r_valid = (k > 0);
         out_r_data = 32'hC0DE_0000 + k;
`ifdef FIR_TCDM_ARB_BURST_LOCK_EN
         exp_p = (k / 4) % MP;
`else
         exp_p = k % MP;
`endif
         #1;
         chk("rr_grant", 64'(in_gnt), 64'(MP'(1) << exp_p));
         for (int p = 0; p < MP; p++) pc[p] += int'(in_r_valid[p]);
         step();
      end
      in_req = '0; out_r_valid = 1'b1;
      #1;
      for (int p = 0; p < MP; p++) pc[p] += int'(in_r_valid[p]);
      step();
      out_r_valid = 1'b0;
      for (int p = 0; p < MP; p++) chk("rr_share", 64'(pc[p]), 64'(12 / MP));

      // grants to 2, 0, 1 answered with latency 3
      clear = 1'b1; step(); clear = 1'b0;
      in_req = 3'b100; step();
      in_req = 3'b001; step();
      in_req = 3'b010; step();
      in_req = '0;
      rsp_v[0] = 3'b100; rsp_v[1] = 3'b001; rsp_v[2] = 3'b010;
      rsp_d[0] = 32'h1111_D000; rsp_d[1] = 32'h2222_D001; rsp_d[2] = 32'h3333_D002;
      for (int i = 0; i < 3; i++) begin
         out_r_valid = 1'b1; out_r_data = rsp_d[i];
         #1;
         chk("route_valid", 64'(in_r_valid), 64'(rsp_v[i]));
         chk("route_data", 64'(in_r_data), 64'(rsp_d[i]));
         step();
      end
      out_r_valid = 1'b0;

      // one-cycle reset with two transactions outstanding
      clear = 1'b1; step(); clear = 1'b0;
      in_req = 3'b001; step();
      in_req = 3'b010; step();
      rst_n = 1'b0; in_req = '1;
      #1;
      chk("rst_out_req", 64'(out_req), 64'(0));
      chk("rst_in_gnt", 64'(in_gnt), 64'(0));
      step();
      rst_n = 1'b1; out_gnt = 1'b0;
      #1;
      chk("post_rst_sel", 64'(out_add), 64'(32'h0000_00A0));
      step();
      in_req = '0; out_r_valid = 1'b1;
      #1;
      chk("post_rst_no_valid", 64'(in_r_valid), 64'(0));
      step();
      out_r_valid = 1'b0;
      #1;
      chk("post_rst_err", 64'(err), 64'(1));
      step();
      clear = 1'b1; step(); clear = 1'b0;

      // randomized traffic against the model
      for (int i = 0; i < 500; i++) begin
         enable      = ($urandom_range(0, 9) != 0);
         in_req      = MP'($urandom_range(0, 7));
         out_gnt     = ($urandom_range(0, 3) != 0);
         out_r_valid = (m_q.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 19) == 0);
         clear       = ($urandom_range(0, 59) == 0);
         in_add      = {$urandom, $urandom, $urandom};
         in_data     = {$urandom, $urandom, $urandom};
         in_be       = (MP*BW)'($urandom);
         in_wen      = MP'($urandom);
         out_r_data  = $urandom;
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fir_tcdm_arbiter.md
FIR_TCDM_ARBITER -- requirements
Module: fir_tcdm_arbiter

Interface
REQ-001 SHALL have parameter MP, default 3, number of requester ports (x, h, y streams; index order X_STREAM_IDX, H_STREAM_IDX, Y_STREAM_IDX).
REQ-002 SHALL have parameter DW, default 32, TCDM data width.
REQ-003 SHALL have parameter AW, default 32, TCDM address width.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 4, in-flight transaction capacity (power of 2, at least 2).
REQ-005 SHALL provide the following ports:
- clk_i  in  1  clock; one clock domain only.
- rst_ni  in  1  reset; synchronous, active-low.
- enable_i  in  1  local enable; 0 blocks new grants.
- clear_i  in  1  synchronous soft clear.
- in_req_i  in  MP  per-port request.
- in_gnt_o  out  MP  per-port grant.
- in_add_i  in  MP*AW  per-port address.
- in_wen_i  in  MP  per-port write-enable-negated (1 = read).
- in_be_i  in  MP*DW/8  per-port byte enable.
- in_data_i  in  MP*DW  per-port write data.
- in_r_data_o  out  DW  response data, broadcast to all ports.
- in_r_valid_o  out  MP  per-port response valid.
- out_req_o  out  1  shared TCDM request.
- out_gnt_i  in  1  shared TCDM grant.
- out_add_o  out  AW  muxed address.
- out_wen_o  out  1  muxed write-enable-negated.
- out_be_o  out  DW/8  muxed byte enable.
- out_data_o  out  DW  muxed write data.
- out_r_data_i  in  DW  TCDM response data.
- out_r_valid_i  in  1  TCDM response valid.
- err_o  out  1  sticky protocol error.

Function
REQ-006 SHALL select sel, the first port p with in_req_i[p]=1 scanning cyclically from pointer ptr (reset 0).
REQ-007 SHALL drive out_req_o = enable_i & |in_req_i & (cnt < MAX_OUTSTANDING); out_add_o, out_wen_o, out_be_o and out_data_o SHALL be taken from port sel, combinationally.
REQ-008 SHALL drive in_gnt_o[sel] = out_req_o & out_gnt_i; all other grant bits SHALL be 0; at most one grant bit SHALL be high per cycle.
REQ-009 SHALL treat out_req_o & out_gnt_i as an accepted transaction: push sel into an in-order ID FIFO (depth MAX_OUTSTANDING) and advance ptr to (sel+1) mod MP.
REQ-010 SHALL expect exactly one out_r_valid_i for every accepted transaction, read or write, in acceptance order, no earlier than 1 cycle after the grant.
REQ-011 On out_r_valid_i with FIFO non-empty, SHALL pop the head ID h, assert in_r_valid_o[h]=1 in the same cycle (zero latency), and pass out_r_data_i to in_r_data_o unmodified.
REQ-012 Outstanding count cnt SHALL be +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-013 When cnt=MAX_OUTSTANDING (full), SHALL deassert out_req_o even if a pop occurs in the same cycle.
REQ-014 On out_r_valid_i with FIFO empty, SHALL assert no in_r_valid_o bit and set err_o=1 until reset or clear.
REQ-015 When enable_i=0, SHALL issue no new grants, SHALL still route responses and SHALL leave ptr unchanged.
REQ-016 When no port requests, SHALL keep out_req_o=0 and ptr unchanged.
REQ-017 SHALL wrap ptr from MP-1 to 0; SHALL wrap FIFO read and write pointers modulo MAX_OUTSTANDING.
REQ-018 On clear_i=1, SHALL zero ptr, cnt, FIFO pointers, err_o and any lock state; clear SHALL take priority over push and pop in that cycle; clear during in-flight transactions discards their routing (bench responsibility).

Reset
REQ-019 While rst_ni=0 at a clock edge, SHALL set ptr=0, cnt=0, FIFO pointers=0, err_o=0 and burst counter=0.
REQ-020 While rst_ni=0, SHALL force out_req_o=0, in_gnt_o=0 and in_r_valid_o=0 combinationally.
REQ-021 Reset mid-operation SHALL drop all outstanding IDs; the first cycle after release SHALL behave as post-power-up.

Configuration
REQ-022 With macro FIR_TCDM_ARB_BURST_LOCK_EN defined, after a grant to port p SHALL keep ptr=p while in_req_i[p] stays 1, for up to 4 consecutive grants (2-bit burst counter), then advance to (p+1) mod MP.
REQ-023 With FIR_TCDM_ARB_BURST_LOCK_EN defined, a cycle with in_req_i[p]=0 SHALL end the lock, reset the counter and advance ptr to (p+1) mod MP.
REQ-024 Without FIR_TCDM_ARB_BURST_LOCK_EN, SHALL implement no burst counter and apply REQ-009 pure round-robin.

Verification
REQ-025 All 3 ports requesting continuously, out_gnt_i=1, immediate responses, no lock -> grants 0,1,2,0,1,2; each port receives 1 in 3 responses.
REQ-026 Same stimulus with FIR_TCDM_ARB_BURST_LOCK_EN -> grants 0,0,0,0,1,1,1,1,2,2,2,2.
REQ-027 out_r_valid_i held 0, port 1 requesting with out_gnt_i=1 -> 4 grants, then out_req_o=0; one response re-enables a request the following cycle.
REQ-028 Grants to ports 2, 0, 1 followed by responses D0, D1, D2 (latency 3) -> in_r_valid_o = 100, 001, 010 with in_r_data_o = D0, D1, D2.
REQ-029 out_r_valid_i=1 with cnt=0 -> err_o=1 and in_r_valid_o=0; err_o clears on clear_i=1.
REQ-030 rst_ni=0 for 1 cycle with 2 outstanding -> cnt=0, ptr=0; a subsequent out_r_valid_i sets err_o.
